// File: rtl/matrix_pkg.sv
// rtl/matrix_pkg.sv - shared constants, element offset helper and controller state encoding
package matrix_pkg;

  localparam int DATA_W  = 8;
  localparam int DIM_MAX = 5;
  localparam int MAT_W   = DIM_MAX * DIM_MAX * DATA_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  // Bit offset of element (i,j) in a packed row-major matrix.
  function automatic int elem_offset(input int i, input int j);
    return (i * DIM_MAX + j) * DATA_W;
  endfunction

endpackage

// File: rtl/matrix_op_arbiter_if.sv
// rtl/matrix_op_arbiter_if.sv - requester, response and unit-side signals of the shared matrix unit
interface matrix_op_arbiter_if #(
  parameter int N_REQ = 2
);
  import matrix_pkg::*;

  logic [N_REQ-1:0]       req;
  logic [3*N_REQ-1:0]     req_m;
  logic [3*N_REQ-1:0]     req_n;
  logic [MAT_W*N_REQ-1:0] req_mat;
  logic [N_REQ-1:0]       grant;
  logic [N_REQ-1:0]       resp_valid;
  logic [N_REQ-1:0]       resp_ready;
  logic [2:0]             resp_m;
  logic [2:0]             resp_n;
  logic [MAT_W-1:0]       resp_mat;
  logic                   resp_err;
  logic                   busy;
  logic [2:0]             u_m_in;
  logic [2:0]             u_n_in;
  logic [MAT_W-1:0]       u_mat_in;
  logic [2:0]             u_m_out;
  logic [2:0]             u_n_out;
  logic [MAT_W-1:0]       u_mat_out;
  logic                   u_valid;

  // master: requesters plus the matrix unit; slave: the arbiter
  modport master (
    output req, req_m, req_n, req_mat, resp_ready,
    output u_m_out, u_n_out, u_mat_out, u_valid,
    input  grant, resp_valid, resp_m, resp_n, resp_mat, resp_err, busy,
    input  u_m_in, u_n_in, u_mat_in
  );

  modport slave (
    input  req, req_m, req_n, req_mat, resp_ready,
    input  u_m_out, u_n_out, u_mat_out, u_valid,
    output grant, resp_valid, resp_m, resp_n, resp_mat, resp_err, busy,
    output u_m_in, u_n_in, u_mat_in
  );

endinterface

// File: rtl/matrix_op_arbiter_rr_arbiter.sv
// rtl/matrix_op_arbiter_rr_arbiter.sv - combinational round-robin pick starting after last_owner
module rr_arbiter #(
  parameter int N_REQ = 2,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDX_W-1:0] last_owner_i,
  output logic [N_REQ-1:0] winner_o,
  output logic [IDX_W-1:0] winner_idx_o
);

  logic found;

  always_comb begin
    winner_o     = '0;
    winner_idx_o = '0;
    found        = 1'b0;
    for (int s = 1; s <= N_REQ; s++) begin
      for (int k = 0; k < N_REQ; k++) begin
        if (!found && req_i[k] && (k == (int'(last_owner_i) + s) % N_REQ)) begin
          found           = 1'b1;
          winner_o[k]     = 1'b1;
          winner_idx_o    = IDX_W'(k);
        end
      end
    end
  end

endmodule

// File: rtl/matrix_op_arbiter.sv
// rtl/matrix_op_arbiter.sv - shares one combinational matrix unit among N_REQ requesters
// Round-robin grant, operand latch, fixed settle wait, then a valid/ready response to the owner.
module matrix_op_arbiter #(
  parameter int N_REQ         = 2,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic               clk_i,
  input  logic               reset_i,
  matrix_op_arbiter_if.slave bus
);
  import matrix_pkg::*;

  localparam int               IDX_W     = $clog2(N_REQ);
  localparam int               CNT_W     = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [IDX_W-1:0] OWNER_RST = IDX_W'(N_REQ - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [N_REQ-1:0] resp_valid_q, resp_valid_d;
  logic [2:0]       u_m_q, u_m_d, u_n_q, u_n_d;
  logic [MAT_W-1:0] u_mat_q, u_mat_d;
  logic [2:0]       resp_m_q, resp_m_d, resp_n_q, resp_n_d;
  logic [MAT_W-1:0] resp_mat_q, resp_mat_d;
  logic             resp_err_q, resp_err_d;

  logic [N_REQ-1:0] win_oh;
  logic [IDX_W-1:0] win_idx;
  logic [N_REQ-1:0] owner_oh;
  logic [2:0]       sel_m, sel_n;
  logic [MAT_W-1:0] sel_mat;
  logic             owner_ready;

  rr_arbiter #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_rr (
    .req_i        (bus.req),
    .last_owner_i (owner_q),
    .winner_o     (win_oh),
    .winner_idx_o (win_idx)
  );

  always_comb begin
    sel_m    = '0;
    sel_n    = '0;
    sel_mat  = '0;
    owner_oh = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (win_oh[k]) begin
        sel_m   = bus.req_m[3*k +: 3];
        sel_n   = bus.req_n[3*k +: 3];
        sel_mat = bus.req_mat[MAT_W*k +: MAT_W];
      end
      if (owner_q == IDX_W'(k)) begin
        owner_oh[k] = 1'b1;
      end
    end
  end

  assign owner_ready = |(bus.resp_ready & owner_oh);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    owner_d      = owner_q;
    grant_d      = '0;
    resp_valid_d = resp_valid_q;
    u_m_d        = u_m_q;
    u_n_d        = u_n_q;
    u_mat_d      = u_mat_q;
    resp_m_d     = resp_m_q;
    resp_n_d     = resp_n_q;
    resp_mat_d   = resp_mat_q;
    resp_err_d   = resp_err_q;
    case (state_q)
      IDLE: begin
        if (|bus.req) begin
          u_m_d   = sel_m;
          u_n_d   = sel_n;
          u_mat_d = sel_mat;
          owner_d = win_idx;
          grant_d = win_oh;
          cnt_d   = '0;
          state_d = EXEC;
        end
      end
      EXEC: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          resp_m_d   = bus.u_m_out;
          resp_n_d   = bus.u_n_out;
          resp_mat_d = bus.u_mat_out;
          resp_err_d = ~bus.u_valid;
          state_d    = RESP;
        end
      end
      RESP: begin
        // First RESP cycle raises valid; the handshake can only land once valid is visible.
        if (resp_valid_q == '0) begin
          resp_valid_d = owner_oh;
        end else if (owner_ready) begin
          resp_valid_d = '0;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      owner_q      <= OWNER_RST;
      grant_q      <= '0;
      resp_valid_q <= '0;
      u_m_q        <= '0;
      u_n_q        <= '0;
      u_mat_q      <= '0;
      resp_m_q     <= '0;
      resp_n_q     <= '0;
      resp_mat_q   <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      owner_q      <= owner_d;
      grant_q      <= grant_d;
      resp_valid_q <= resp_valid_d;
      u_m_q        <= u_m_d;
      u_n_q        <= u_n_d;
      u_mat_q      <= u_mat_d;
      resp_m_q     <= resp_m_d;
      resp_n_q     <= resp_n_d;
      resp_mat_q   <= resp_mat_d;
      resp_err_q   <= resp_err_d;
    end
  end

  assign bus.grant      = grant_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_m     = resp_m_q;
  assign bus.resp_n     = resp_n_q;
  assign bus.resp_mat   = resp_mat_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.busy       = (state_q != IDLE);
  assign bus.u_m_in     = u_m_q;
  assign bus.u_n_in     = u_n_q;
  assign bus.u_mat_in   = u_mat_q;

endmodule

// File: tb/tb_matrix_op_arbiter.sv
// tb/tb_matrix_op_arbiter.sv - directed vector table plus hand sequences for matrix_op_arbiter
module tb_matrix_op_arbiter;
  import matrix_pkg::*;

  typedef struct packed {
    logic [2:0]       m;
    logic [2:0]       n;
    logic [MAT_W-1:0] mat;
    logic             v;
  } unit_res_t;

  typedef struct {
    logic [1:0] req;
    logic [2:0] m0, n0, m1, n1;
    logic [7:0] b0, b1;
    logic [1:0] exp_grant;
    logic [2:0] exp_m, exp_n;
    logic       exp_err;
    logic [7:0] exp_b;
  } vec_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  matrix_op_arbiter_if #(.N_REQ(2)) if1 ();
  matrix_op_arbiter_if #(.N_REQ(2)) if3 ();

  matrix_op_arbiter #(.N_REQ(2), .SETTLE_CYCLES(1)) dut1 (.clk_i(clk), .reset_i(reset), .bus(if1));
  matrix_op_arbiter #(.N_REQ(2), .SETTLE_CYCLES(3)) dut3 (.clk_i(clk), .reset_i(reset), .bus(if3));

  // Transpose unit stand-in: valid dims 1..5, otherwise zeros with valid low.
  function automatic unit_res_t unit_f(input logic [2:0] m, input logic [2:0] n, input logic [MAT_W-1:0] a);
    unit_res_t r;
    int mi, ni;
    r  = '0;
    mi = int'(m);
    ni = int'(n);
    if (mi >= 1 && mi <= DIM_MAX && ni >= 1 && ni <= DIM_MAX) begin
      r.v = 1'b1;
      r.m = n;
      r.n = m;
      for (int i = 0; i < DIM_MAX; i++)
        for (int j = 0; j < DIM_MAX; j++)
          if (i < mi && j < ni) r.mat[elem_offset(j, i) +: DATA_W] = a[elem_offset(i, j) +: DATA_W];
    end
    return r;
  endfunction

  unit_res_t ur1, ur3;
  assign ur1 = unit_f(if1.u_m_in, if1.u_n_in, if1.u_mat_in);
  assign ur3 = unit_f(if3.u_m_in, if3.u_n_in, if3.u_mat_in);
  assign if1.u_m_out = ur1.m;
  assign if1.u_n_out = ur1.n;
  assign if1.u_mat_out = ur1.mat;
  assign if1.u_valid = ur1.v;
  assign if3.u_m_out = ur3.m;
  assign if3.u_n_out = ur3.n;
  assign if3.u_mat_out = ur3.mat;
  assign if3.u_valid = ur3.v;

  function automatic logic [MAT_W-1:0] put(input logic [MAT_W-1:0] a, input int r, input int c, input logic [7:0] v);
    logic [MAT_W-1:0] t;
    t = a;
    t[elem_offset(r, c) +: DATA_W] = v;
    return t;
  endfunction

  // Source element (i,j) = base + 16*i + j inside the m x n window.
  function automatic logic [MAT_W-1:0] src_mat(input logic [7:0] base, input int m, input int n);
    logic [MAT_W-1:0] t;
    t = '0;
    for (int i = 0; i < DIM_MAX; i++)
      for (int j = 0; j < DIM_MAX; j++)
        if (i < m && j < n) t[elem_offset(i, j) +: DATA_W] = base + 8'(i * 16 + j);
    return t;
  endfunction

  // Expected result element (r,c) = source (c,r) = base + 16*c + r.
  function automatic logic [MAT_W-1:0] exp_mat(input logic [7:0] base, input int rows, input int cols);
    logic [MAT_W-1:0] t;
    t = '0;
    for (int r = 0; r < DIM_MAX; r++)
      for (int c = 0; c < DIM_MAX; c++)
        if (r < rows && c < cols) t[elem_offset(r, c) +: DATA_W] = base + 8'(c * 16 + r);
    return t;
  endfunction

  task automatic chk(input string name, input logic [MAT_W-1:0] act, input logic [MAT_W-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic timeout_fail(input string name);
    n_checks++;
    $display("FAIL %s: no event within 20 cycles, expected one", name);
  endtask

  task automatic wait_grant1(input string name);
    int k;
    k = 0;
    while (if1.grant == 2'b00 && k < 20) begin @(negedge clk); k++; end
    if (if1.grant == 2'b00) timeout_fail({name, "_grant_wait"});
  endtask

  task automatic wait_valid1(input string name);
    int k;
    k = 0;
    while (if1.resp_valid == 2'b00 && k < 20) begin @(negedge clk); k++; end
    if (if1.resp_valid == 2'b00) timeout_fail({name, "_valid_wait"});
  endtask

  task automatic wait_idle1(input string name);
    int k;
    k = 0;
    while (if1.busy && k < 20) begin @(negedge clk); k++; end
    if (if1.busy) timeout_fail({name, "_idle_wait"});
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    string nm;
    nm = $sformatf("v%0d", idx);
    @(negedge clk);
    if1.req        = v.req;
    if1.req_m      = {v.m1, v.m0};
    if1.req_n      = {v.n1, v.n0};
    if1.req_mat    = {src_mat(v.b1, int'(v.m1), int'(v.n1)), src_mat(v.b0, int'(v.m0), int'(v.n0))};
    if1.resp_ready = 2'b11;
    wait_grant1(nm);
    chk({nm, "_grant"}, if1.grant, v.exp_grant);
    @(negedge clk);
    if1.req = 2'b00;
    chk({nm, "_grant_pulse"}, if1.grant, 0);
    wait_valid1(nm);
    chk({nm, "_valid"}, if1.resp_valid, v.exp_grant);
    chk({nm, "_m"}, if1.resp_m, v.exp_m);
    chk({nm, "_n"}, if1.resp_n, v.exp_n);
    chk({nm, "_err"}, if1.resp_err, v.exp_err);
    chk({nm, "_mat"}, if1.resp_mat, exp_mat(v.exp_b, int'(v.exp_m), int'(v.exp_n)));
    wait_idle1(nm);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at 200000, expected finish");
    $fatal(1, "watchdog expired");
  end

  vec_t             vecs [9];
  logic [MAT_W-1:0] m1, e1, hold_exp, m3, e3;

  initial begin
    vecs[0] = '{2'b11, 3'd2, 3'd3, 3'd3, 3'd2, 8'h10, 8'h40, 2'b10, 3'd2, 3'd3, 1'b0, 8'h40};
    vecs[1] = '{2'b11, 3'd2, 3'd3, 3'd3, 3'd2, 8'h10, 8'h40, 2'b01, 3'd3, 3'd2, 1'b0, 8'h10};
    vecs[2] = '{2'b11, 3'd4, 3'd1, 3'd1, 3'd4, 8'h20, 8'h50, 2'b10, 3'd4, 3'd1, 1'b0, 8'h50};
    vecs[3] = '{2'b11, 3'd4, 3'd1, 3'd1, 3'd4, 8'h20, 8'h50, 2'b01, 3'd1, 3'd4, 1'b0, 8'h20};
    vecs[4] = '{2'b10, 3'd0, 3'd0, 3'd0, 3'd4, 8'h00, 8'h60, 2'b10, 3'd0, 3'd0, 1'b1, 8'h00};
    vecs[5] = '{2'b01, 3'd5, 3'd5, 3'd0, 3'd0, 8'h00, 8'h00, 2'b01, 3'd5, 3'd5, 1'b0, 8'h00};
    vecs[6] = '{2'b01, 3'd1, 3'd5, 3'd0, 3'd0, 8'h30, 8'h00, 2'b01, 3'd5, 3'd1, 1'b0, 8'h30};
    vecs[7] = '{2'b10, 3'd0, 3'd0, 3'd6, 3'd2, 8'h00, 8'h70, 2'b10, 3'd0, 3'd0, 1'b1, 8'h00};
    vecs[8] = '{2'b01, 3'd5, 3'd7, 3'd0, 3'd0, 8'h08, 8'h00, 2'b01, 3'd0, 3'd0, 1'b1, 8'h00};

    if1.req = '0; if1.req_m = '0; if1.req_n = '0; if1.req_mat = '0; if1.resp_ready = '0;
    if3.req = '0; if3.req_m = '0; if3.req_n = '0; if3.req_mat = '0; if3.resp_ready = '0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_busy", if1.busy, 0);
    chk("rst_grant", if1.grant, 0);
    chk("rst_valid", if1.resp_valid, 0);
    chk("rst_err", if1.resp_err, 0);
    chk("rst_u_m", if1.u_m_in, 0);
    chk("rst_resp_mat", if1.resp_mat, 0);
    chk("rst3_busy", if3.busy, 0);
    reset = 1'b0;

    // First transaction with exact cycle timing
    m1 = '0;
    m1 = put(m1, 0, 0, 8'd1); m1 = put(m1, 0, 1, 8'd2); m1 = put(m1, 0, 2, 8'd3);
    m1 = put(m1, 1, 0, 8'd4); m1 = put(m1, 1, 1, 8'd5); m1 = put(m1, 1, 2, 8'd6);
    e1 = '0;
    e1 = put(e1, 0, 0, 8'd1); e1 = put(e1, 0, 1, 8'd4);
    e1 = put(e1, 1, 0, 8'd2); e1 = put(e1, 1, 1, 8'd5);
    e1 = put(e1, 2, 0, 8'd3); e1 = put(e1, 2, 1, 8'd6);
    @(negedge clk);
    if1.req = 2'b01; if1.req_m = {3'd0, 3'd2}; if1.req_n = {3'd0, 3'd3};
    if1.req_mat = {{MAT_W{1'b0}}, m1};
    @(negedge clk);
    chk("b_grant", if1.grant, 2'b01);
    chk("b_busy", if1.busy, 1);
    chk("b_u_m", if1.u_m_in, 3'd2);
    chk("b_u_n", if1.u_n_in, 3'd3);
    chk("b_u_mat", if1.u_mat_in, m1);
    if1.req = 2'b00;
    @(negedge clk);
    chk("b_grant_pulse", if1.grant, 0);
    chk("b_valid_early", if1.resp_valid, 0);
    @(negedge clk);
    chk("b_valid", if1.resp_valid, 2'b01);
    chk("b_m", if1.resp_m, 3'd3);
    chk("b_n", if1.resp_n, 3'd2);
    chk("b_err", if1.resp_err, 0);
    chk("b_mat", if1.resp_mat, e1);
    if1.resp_ready = 2'b01;
    @(negedge clk);
    chk("b_valid_done", if1.resp_valid, 0);
    chk("b_idle", if1.busy, 0);

    for (int i = 0; i < 9; i++) run_vec(vecs[i], i);

    // Owner stalls with resp_ready low while requester 1 waits
    @(negedge clk);
    if1.req = 2'b01; if1.req_m = {3'd0, 3'd2}; if1.req_n = {3'd0, 3'd2};
    if1.req_mat = {{MAT_W{1'b0}}, src_mat(8'h70, 2, 2)};
    if1.resp_ready = 2'b00;
    wait_grant1("hold");
    chk("hold_grant", if1.grant, 2'b01);
    @(negedge clk);
    if1.req = 2'b00;
    wait_valid1("hold");
    hold_exp = exp_mat(8'h70, 2, 2);
    if1.req = 2'b10; if1.req_m = {3'd3, 3'd2}; if1.req_n = {3'd3, 3'd2};
    if1.req_mat = {src_mat(8'h80, 3, 3), src_mat(8'h70, 2, 2)};
    if1.resp_ready = 2'b10;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk($sformatf("hold%0d_valid", i), if1.resp_valid, 2'b01);
      chk($sformatf("hold%0d_grant", i), if1.grant, 0);
      chk($sformatf("hold%0d_mat", i), if1.resp_mat, hold_exp);
    end
    if1.resp_ready = 2'b01;
    @(negedge clk);
    chk("hold_rel_valid", if1.resp_valid, 0);
    chk("hold_rel_busy", if1.busy, 0);
    chk("hold_rel_grant", if1.grant, 0);
    @(negedge clk);
    chk("hold_next_grant", if1.grant, 2'b10);
    if1.req = 2'b00;
    if1.resp_ready = 2'b11;
    wait_valid1("hold_next");
    chk("hold_next_valid", if1.resp_valid, 2'b10);
    chk("hold_next_mat", if1.resp_mat, exp_mat(8'h80, 3, 3));
    wait_idle1("hold_next");

    // Reset while in EXEC drops the operation and restores the pointer
    @(negedge clk);
    if1.req = 2'b01; if1.req_m = {3'd2, 3'd2}; if1.req_n = {3'd2, 3'd2};
    if1.req_mat = {src_mat(8'h22, 2, 2), src_mat(8'h33, 2, 2)};
    if1.resp_ready = 2'b00;
    @(negedge clk);
    chk("rx_grant", if1.grant, 2'b01);
    if1.req = 2'b00;
    reset = 1'b1;
    @(negedge clk);
    chk("rx_busy", if1.busy, 0);
    chk("rx_valid", if1.resp_valid, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("rx_no_resp", if1.resp_valid, 0);
    chk("rx_idle", if1.busy, 0);
    if1.req = 2'b11;
    if1.req_mat = {src_mat(8'h22, 2, 2), src_mat(8'h11, 2, 2)};
    wait_grant1("rx2");
    chk("rx2_grant", if1.grant, 2'b01);
    @(negedge clk);
    if1.req = 2'b00;
    if1.resp_ready = 2'b11;
    wait_valid1("rx2");
    chk("rx2_valid", if1.resp_valid, 2'b01);
    chk("rx2_mat", if1.resp_mat, exp_mat(8'h11, 2, 2));
    wait_idle1("rx2");

    // Three-cycle settle with a full 5x5 matrix
    m3 = put(src_mat(8'h00, 5, 5), 4, 0, 8'hA5);
    e3 = put(exp_mat(8'h00, 5, 5), 0, 4, 8'hA5);
    @(negedge clk);
    if3.req = 2'b01; if3.req_m = {3'd0, 3'd5}; if3.req_n = {3'd0, 3'd5};
    if3.req_mat = {{MAT_W{1'b0}}, m3};
    @(negedge clk);
    chk("s3_grant", if3.grant, 2'b01);
    if3.req = 2'b00;
    if3.req_mat = {MAT_W*2{1'b1}};
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("s3_u_mat%0d", i), if3.u_mat_in, m3);
      chk($sformatf("s3_u_m%0d", i), if3.u_m_in, 3'd5);
      chk($sformatf("s3_valid_low%0d", i), if3.resp_valid, 0);
      @(negedge clk);
    end
    chk("s3_valid_low3", if3.resp_valid, 0);
    chk("s3_busy", if3.busy, 1);
    @(negedge clk);
    chk("s3_valid", if3.resp_valid, 2'b01);
    chk("s3_elem_0_4", if3.resp_mat[elem_offset(0, 4) +: DATA_W], 8'hA5);
    chk("s3_mat", if3.resp_mat, e3);
    chk("s3_m", if3.resp_m, 3'd5);
    chk("s3_err", if3.resp_err, 0);
    if3.resp_ready = 2'b01;
    @(negedge clk);
    chk("s3_valid_done", if3.resp_valid, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
